// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester round-robin arbiter in front of one shared,
//            purely combinational 4-bit ALU (AND / ADD). A granted request
//            is latched, fed to the ALU for SETTLE_CYCLES cycles, and the ALU
//            output is captured into a result register before done pulses.
// Ports    : clk, reset_n (sync, active-low)
//            req0/req1, op0/op1 (0 = AND, 1 = ADD), a0/b0/a1/b1 : requesters
//            alu_left/alu_right (AND/ADD select), alu_a/alu_b : to the ALU
//            alu_result                                       : from the ALU
//            gnt0/gnt1, done0/done1 : one-cycle pulses
//            result : last completed result, busy : not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1  // legal range 1..15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       op0,
  input  logic       op1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [3:0] alu_result,
  output logic       alu_left,
  output logic       alu_right,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Value of the settle counter on the final EXEC cycle.
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;     // requester being served (0/1)
  logic       last_q, last_d;   // requester served most recently
  logic       op_q, op_d;
  logic [3:0] opa_q, opa_d;
  logic [3:0] opb_q, opb_d;

  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       left_q, left_d;
  logic       right_q, right_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [3:0] result_q, result_d;
  logic       busy_q, busy_d;

  // Every output is a flop, so each one is computed from the state being
  // entered rather than decoded from the current state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    last_d   = last_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    left_d   = 1'b0;
    right_d  = 1'b0;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          sel_d   = (req0 && req1) ? ~last_q : req1;
          op_d    = sel_d ? op1 : op0;
          opa_d   = sel_d ? a1  : a0;
          opb_d   = sel_d ? b1  : b0;
          gnt0_d  = ~sel_d;
          gnt1_d  = sel_d;
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = EXEC;
        cnt_d   = 4'd0;
        alu_a_d = opa_q;
        alu_b_d = opb_q;
        left_d  = ~op_q;
        right_d = op_q;
      end
      EXEC: begin
        if (cnt_q == LAST_CNT) begin
          // Operands have been stable for SETTLE_CYCLES cycles: capture.
          result_d = alu_result;
          done0_d  = ~sel_q;
          done1_d  = sel_q;
          state_d  = DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          left_d  = ~op_q;
          right_d = op_q;
        end
      end
      DONE: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;  // "requester 1 served last" => requester 0 wins first tie
      op_q     <= 1'b0;
      opa_q    <= 4'd0;
      opb_q    <= 4'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      alu_a_q  <= 4'd0;
      alu_b_q  <= 4'd0;
      result_q <= 4'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      left_q   <= left_d;
      right_q  <= right_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign alu_left  = left_q;
  assign alu_right = right_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. Two instances run side by
//            side (SETTLE_CYCLES = 1 and 3) on shared requester inputs, each
//            with its own behavioural ALU. A transaction-level reference
//            model predicts every output of both instances every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, req0, req1, op0, op1;
  logic [3:0] a0, b0, a1, b1;

  // index 0 -> SETTLE_CYCLES = 1, index 1 -> SETTLE_CYCLES = 3
  logic [1:0]      alu_left, alu_right, gnt0, gnt1, done0, done1, busy;
  logic [1:0][3:0] alu_a, alu_b, alu_result, result;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int unsigned edge_n = 0;

  function automatic logic [3:0] alu_env(input logic l, input logic r,
                                         input logic [3:0] a, input logic [3:0] b);
    // Unselected ALU drives junk so a mistimed capture is visible.
    return l ? (a & b) : (r ? 4'(a + b) : ~a);
  endfunction

  assign alu_result[0] = alu_env(alu_left[0], alu_right[0], alu_a[0], alu_b[0]);
  assign alu_result[1] = alu_env(alu_left[1], alu_right[1], alu_a[1], alu_b[1]);

  alu_arbiter #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .alu_result(alu_result[0]),
    .alu_left(alu_left[0]), .alu_right(alu_right[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
    .result(result[0]), .busy(busy[0])
  );

  alu_arbiter #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .alu_result(alu_result[1]),
    .alu_left(alu_left[1]), .alu_right(alu_right[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
    .result(result[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not seen within cycle budget (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [18:0] pack(input int k);
    return {gnt0[k], gnt1[k], done0[k], done1[k], busy[k], alu_left[k], alu_right[k],
            alu_a[k], alu_b[k], result[k]};
  endfunction

  function automatic int s_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ---------------- reference model (transaction timeline) -----------------
  // A transaction sampled at edge t0 occupies edges t0..t0+S+2: grant visible
  // after t0, operands presented after t0+1, result captured at t0+S+1,
  // arbiter free again after t0+S+2 (samples requests from t0+S+3 on).
  bit         m_active[2] = '{1'b0, 1'b0};
  int unsigned m_t0[2];
  bit         m_who[2], m_op[2];
  bit         m_last[2] = '{1'b1, 1'b1};
  logic [3:0] m_a[2], m_b[2];
  logic [3:0] m_alu_a[2] = '{4'd0, 4'd0};
  logic [3:0] m_alu_b[2] = '{4'd0, 4'd0};
  logic [3:0] m_res[2]   = '{4'd0, 4'd0};

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_active[k] = 1'b0;
        m_last[k]   = 1'b1;
        m_res[k]    = 4'd0;
        m_alu_a[k]  = 4'd0;
        m_alu_b[k]  = 4'd0;
      end else if (!m_active[k]) begin
        if (req0 || req1) begin
          m_who[k]    = (req0 && req1) ? !m_last[k] : req1;
          m_op[k]     = m_who[k] ? op1 : op0;
          m_a[k]      = m_who[k] ? a1 : a0;
          m_b[k]      = m_who[k] ? b1 : b0;
          m_t0[k]     = edge_n;
          m_active[k] = 1'b1;
        end
      end else begin
        if (edge_n == m_t0[k] + 1) begin
          m_alu_a[k] = m_a[k];
          m_alu_b[k] = m_b[k];
        end
        if (edge_n == m_t0[k] + 1 + s_of(k))
          m_res[k] = m_op[k] ? ((m_a[k] + m_b[k]) % 16) : (m_a[k] & m_b[k]);
        if (edge_n == m_t0[k] + 2 + s_of(k)) begin
          m_last[k]   = m_who[k];
          m_active[k] = 1'b0;
        end
      end
    end
  end

  logic [18:0] exp_v;
  bit          e_g, e_d, e_s;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        e_g = m_active[k] && (edge_n == m_t0[k]);
        e_d = m_active[k] && (edge_n == m_t0[k] + 1 + s_of(k));
        e_s = m_active[k] && (edge_n >= m_t0[k] + 1) && (edge_n <= m_t0[k] + s_of(k));
        exp_v = {e_g && !m_who[k], e_g && m_who[k], e_d && !m_who[k], e_d && m_who[k],
                 m_active[k], e_s && !m_op[k], e_s && m_op[k],
                 m_alu_a[k], m_alu_b[k], m_res[k]};
        check($sformatf("model dut%0d edge %0d", k, edge_n), 32'(pack(k)), 32'(exp_v));
      end
    end
  end

  // ---------------- directed vectors ----------------------------------------
  typedef struct {
    logic       r0, r1, o0, o1;
    logic [3:0] a0, b0, a1, b1;
    logic       g0, g1;
    logic [3:0] res;
  } vec_t;

  vec_t tbl[7];

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 12 && !ok; t++) begin
      tick();
      if (!busy[0] && !busy[1]) ok = 1'b1;
    end
    if (!ok) timeout(name);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int          sel_cnt, d3_at, d1_at;
  bit          got, seen0, seen1;
  int unsigned last_g;

  initial begin
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
    a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;

    //          r0    r1    o0    o1    a0       b0       a1       b1       g0    g1    res
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 4'b1010, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1100, 4'b1010, 1'b0, 1'b1, 4'b0110};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0011, 4'b0001, 4'b0011, 1'b1, 1'b0, 4'b0100};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0011, 4'b0001, 4'b0011, 1'b0, 1'b1, 4'b0001};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 4'b0101, 4'b0101, 1'b1, 1'b0, 4'b0000};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, 4'b0011, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b1111};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0111, 4'b0111, 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b1110};

    tick();
    chk_en = 1'b1;
    check("reset state dut1", 32'(pack(0)), 32'd0);
    check("reset state dut3", 32'(pack(1)), 32'd0);
    reset_n = 1'b1;

    // Table: one request pulse per vector, inputs scrambled after the grant.
    for (int i = 0; i < 7; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; op0 = tbl[i].o0; op1 = tbl[i].o1;
      a0 = tbl[i].a0; b0 = tbl[i].b0; a1 = tbl[i].a1; b1 = tbl[i].b1;
      tick();
      check($sformatf("vec%0d gnt", i), {30'd0, gnt0[0], gnt1[0]}, {30'd0, tbl[i].g0, tbl[i].g1});
      req0 = 1'b0; req1 = 1'b0;
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        tick();
        if (done0[0] || done1[0]) begin
          got = 1'b1;
          check($sformatf("vec%0d done", i), {30'd0, done0[0], done1[0]}, {30'd0, tbl[i].g0, tbl[i].g1});
          check($sformatf("vec%0d result", i), 32'(result[0]), 32'(tbl[i].res));
        end
      end
      if (!got) timeout($sformatf("vec%0d done", i));
      wait_idle($sformatf("vec%0d idle", i));
    end

    // Both requesters held after reset: strict alternation, grants 4 cycles apart.
    do_reset();
    req0 = 1'b1; op0 = 1'b1; a0 = 4'b0001; b0 = 4'b0011;
    req1 = 1'b1; op1 = 1'b0; a1 = 4'b0001; b1 = 4'b0011;
    last_g = 0;
    for (int j = 0; j < 4; j++) begin
      got = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
        tick();
        if (gnt0[0] || gnt1[0]) got = 1'b1;
      end
      if (!got) timeout($sformatf("alt grant %0d", j));
      check($sformatf("alt grant %0d who", j), {31'd0, gnt1[0]}, 32'(j % 2));
      if (j > 0) check($sformatf("alt grant %0d spacing", j), 32'(edge_n - last_g), 32'd4);
      last_g = edge_n;
      got = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
        tick();
        if (done0[0] || done1[0]) got = 1'b1;
      end
      if (!got) timeout($sformatf("alt done %0d", j));
      check($sformatf("alt result %0d", j), 32'(result[0]), (j % 2 == 0) ? 32'h4 : 32'h1);
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("alt idle");

    // Latency / select-length for SETTLE_CYCLES = 3 alongside SETTLE_CYCLES = 1.
    req0 = 1'b1; op0 = 1'b0; a0 = 4'b1100; b0 = 4'b1010;
    sel_cnt = 0; d3_at = 0; d1_at = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 1) req0 = 1'b0;
      if (alu_left[1]) sel_cnt++;
      if (done0[1] && d3_at == 0) d3_at = t;
      if (done0[0] && d1_at == 0) d1_at = t;
    end
    check("settle3 select cycles", 32'(sel_cnt), 32'd3);
    check("settle3 done cycle", 32'(d3_at), 32'd5);
    check("settle1 done cycle", 32'(d1_at), 32'd3);
    check("settle3 result", 32'(result[1]), 32'b1000);
    wait_idle("settle idle");

    // Reset during EXEC aborts silently; held request is re-granted afterwards.
    req1 = 1'b1; op1 = 1'b1; a1 = 4'b1100; b1 = 4'b1010;
    tick(); tick();
    check("pre-reset exec select", {30'd0, alu_right}, 32'd3);
    reset_n = 1'b0;
    tick();
    check("mid reset dut1 zero", 32'(pack(0)), 32'd0);
    check("mid reset dut3 zero", 32'(pack(1)), 32'd0);
    reset_n = 1'b1;
    tick();
    check("post reset gnt1", {30'd0, gnt1}, 32'd3);
    req1 = 1'b0;
    wait_idle("post reset idle");
    check("post reset result", 32'(result[0]), 32'b0110);

    // Requester drops and changes operands mid-EXEC: latched operands win.
    req0 = 1'b1; op0 = 1'b1; a0 = 4'b0101; b0 = 4'b0110;
    tick(); tick();
    req0 = 1'b0; op0 = 1'b0; a0 = 4'b1111; b0 = 4'b0000;
    seen0 = 1'b0; seen1 = 1'b0;
    for (int t = 0; t < 10 && !(seen0 && seen1); t++) begin
      tick();
      if (done0[0] && !seen0) begin
        seen0 = 1'b1;
        check("drop dut1 result", 32'(result[0]), 32'b1011);
      end
      if (done0[1] && !seen1) begin
        seen1 = 1'b1;
        check("drop dut3 result", 32'(result[1]), 32'b1011);
      end
    end
    if (!(seen0 && seen1)) timeout("drop done0");
    wait_idle("drop idle");

    // Random traffic, occasional resets; reference model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      op0 = 1'($urandom); op1 = 1'($urandom);
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      tick();
    end
    reset_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, range 1-15: cycles ALU inputs are held stable before result capture.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 req0, req1  input  1 each  requester 0/1 operation request; held high until matching done pulse.
REQ-005 op0, op1  input  1 each  requested operation: 0 = AND, 1 = ADD.
REQ-006 a0, b0, a1, b1  input  4 each  requester operands.
REQ-007 alu_left, alu_right  output  1 each  ALU select lines: left = AND, right = ADD.
REQ-008 alu_a, alu_b  output  4 each  operands to shared ALU.
REQ-009 alu_result  input  4  combinational ALU result.
REQ-010 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands latched this cycle.
REQ-011 done0, done1  output  1 each  one-cycle completion pulse; result valid this cycle.
REQ-012 result  output  4  registered result of last completed operation.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, GRANT, EXEC, DONE; all outputs registered.
REQ-015 IDLE: no req -> IDLE; any req at edge -> GRANT; chosen requester's op/a/b latched internally at that edge.
REQ-016 Arbitration: one req -> that requester; both -> requester other than last served (round-robin pointer); pointer after reset favours requester 0.
REQ-017 GRANT: lasts exactly 1 cycle, gnt of chosen requester high, -> EXEC.
REQ-018 EXEC: lasts exactly SETTLE_CYCLES cycles; alu_a/alu_b = latched operands; exactly one of alu_left/alu_right high per latched op; final edge captures alu_result into result; -> DONE.
REQ-019 DONE: lasts 1 cycle, done of served requester high, result valid, pointer updated to served requester; -> IDLE.
REQ-020 Outside EXEC: alu_left = alu_right = 0; alu_a/alu_b hold last values.
REQ-021 Latency (SETTLE_CYCLES=1): req sampled edge 0 -> gnt cycle 1 -> EXEC cycle 2 -> done cycle 3 -> IDLE cycle 4; next grant earliest cycle 5.
REQ-022 Requester still high in IDLE after its done is re-arbitrated as a new request; both held -> strict alternation 0,1,0,1.
REQ-023 req dropped after grant: operation completes, done still pulses; req/op/a/b changes after latch edge do not affect in-flight operation.
REQ-024 ADD result modulo 16, carry discarded; result holds between done pulses.
REQ-025 gnt0/gnt1 never both high; done0/done1 never both high; at most one ALU select high.

Reset
REQ-026 reset_n low at edge, any state: state -> IDLE; gnt*, done*, alu_left, alu_right, busy, result, alu_a, alu_b -> 0; pointer -> favour requester 0.
REQ-027 Reset mid-operation: no done pulse for aborted operation; requests sampled again first edge after reset_n high.

Verification
REQ-028 req0, op0=0, a0=1100, b0=1010 -> gnt0 cycle 1, alu_left=1 cycle 2, done0 cycle 3, result=1000.
REQ-029 req1, op1=1, a1=1100, b1=1010 -> alu_right=1 during EXEC, done1, result=0110 (carry dropped).
REQ-030 req0 (op0=1, 0001, 0011) and req1 (op1=0, 0001, 0011) same edge after reset -> requester 0 first result=0100, then requester 1 result=0001; both held -> grants alternate 0,1,0,1.
REQ-031 SETTLE_CYCLES=3: alu select held exactly 3 cycles; done 5 cycles after req sample edge.
REQ-032 reset_n low during EXEC -> all outputs 0 next cycle, no done pulse; req held -> fresh grant after reset release.
REQ-033 req0 dropped and a0 changed during EXEC -> done0 still pulses with result from originally latched operands.
